// File: rtl/lbp_scan_ctrl_if.sv
// Handshake and memory bundle between the LBP scan controller and its
// gray memory, LBP datapath and result memory.
interface lbp_scan_ctrl_if;
  logic [5:0]  gray_addr;
  logic        gray_req;
  logic [7:0]  gray_data;
  logic        win_valid;
  logic        win_ready;
  logic [71:0] win_data;
  logic [5:0]  win_addr;
  logic        res_valid;
  logic [7:0]  res_data;
  logic [5:0]  lbp_addr;
  logic [7:0]  lbp_data;
  logic        lbp_write;
  logic        finish;

  modport master (
    output gray_addr, gray_req,
    input  gray_data,
    output win_valid, win_data, win_addr,
    input  win_ready,
    input  res_valid, res_data,
    output lbp_addr, lbp_data, lbp_write, finish
  );

  modport slave (
    input  gray_addr, gray_req,
    output gray_data,
    input  win_valid, win_data, win_addr,
    output win_ready,
    output res_valid, res_data,
    input  lbp_addr, lbp_data, lbp_write, finish
  );
endinterface

// File: rtl/lbp_scan_ctrl.sv
// 8x8 LBP scan controller: walks interior centers, builds 3x3 windows,
// hands them to the datapath and writes back the returned codes.
module lbp_scan_ctrl (
  input  logic clk,
  input  logic reset,
  lbp_scan_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    FETCH, PRESENT, WAIT_RES, WRITE, DONE
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  row, row_nx;
  logic [2:0]  col, col_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [71:0] win, win_nx;
  logic [7:0]  code, code_nx;
  logic        wph, wph_nx;

  logic        full;
  logic [3:0]  last;
  logic [3:0]  rd_off;
  logic [3:0]  cp_off;
  logic [3:0]  cp_k;
  logic [6:0]  cp_lsb;
  logic [2:0]  rd_r;
  logic [2:0]  rd_c;

  logic        req;
  logic        wvalid;
  logic        lwrite;
  logic        fin;
  logic [5:0]  raddr;
  logic [5:0]  laddr;
  logic [7:0]  ldata;

  // {row offset, col offset} of read i; full loads go column-major
  function automatic logic [3:0] offs(
    input logic       f,
    input logic [3:0] i
  );
    logic [3:0] o;
    o = 4'b0000;
    if (!f) begin
      o = {i[1:0], 2'd2};
    end else begin
      unique case (i)
        4'd0:    o = 4'b0000;
        4'd1:    o = 4'b0100;
        4'd2:    o = 4'b1000;
        4'd3:    o = 4'b0001;
        4'd4:    o = 4'b0101;
        4'd5:    o = 4'b1001;
        4'd6:    o = 4'b0010;
        4'd7:    o = 4'b0110;
        4'd8:    o = 4'b1010;
        default: o = 4'b0000;
      endcase
    end
    return o;
  endfunction

  assign full   = (col == 3'd1);
  assign last   = full ? 4'd9 : 4'd3;
  assign rd_off = offs(full, cnt);
  assign cp_off = offs(full, cnt - 4'd1);
  assign cp_k   = {1'b0, cp_off[3:2], 1'b0}
                + {2'b00, cp_off[3:2]}
                + {2'b00, cp_off[1:0]};
  assign cp_lsb = {cp_k, 3'b000};
  assign rd_r   = row - 3'd1 + {1'b0, rd_off[3:2]};
  assign rd_c   = col - 3'd1 + {1'b0, rd_off[1:0]};

  always_comb begin
    state_nx = state;
    row_nx   = row;
    col_nx   = col;
    cnt_nx   = cnt;
    win_nx   = win;
    code_nx  = code;
    wph_nx   = wph;
    req      = 1'b0;
    raddr    = 6'd0;
    wvalid   = 1'b0;
    lwrite   = 1'b0;
    laddr    = 6'd0;
    ldata    = 8'd0;
    fin      = 1'b0;
    unique case (state)
      FETCH: begin
        if (cnt < last) begin
          req   = 1'b1;
          raddr = {rd_r, rd_c};
        end
        // a byte shift moves columns 1,2 into 0,1
        if (cnt == 4'd0) begin
          if (!full) win_nx = win >> 8;
        end else begin
          win_nx[cp_lsb +: 8] = bus.gray_data;
        end
        if (cnt == last) begin
          cnt_nx   = 4'd0;
          state_nx = PRESENT;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      PRESENT: begin
        wvalid = 1'b1;
        if (bus.win_ready) state_nx = WAIT_RES;
      end
      WAIT_RES: begin
        if (bus.res_valid) begin
          code_nx  = bus.res_data;
          state_nx = WRITE;
        end
      end
      WRITE: begin
        laddr  = {row, col};
        ldata  = code;
        lwrite = !wph;
        wph_nx = 1'b1;
        if (wph) begin
          wph_nx   = 1'b0;
          state_nx = FETCH;
          if (col < 3'd6) begin
            col_nx = col + 3'd1;
          end else if (row < 3'd6) begin
            row_nx = row + 3'd1;
            col_nx = 3'd1;
          end else begin
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        fin = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      row   <= 3'd1;
      col   <= 3'd1;
      cnt   <= 4'd0;
      win   <= 72'd0;
      code  <= 8'd0;
      wph   <= 1'b0;
    end else begin
      state <= state_nx;
      row   <= row_nx;
      col   <= col_nx;
      cnt   <= cnt_nx;
      win   <= win_nx;
      code  <= code_nx;
      wph   <= wph_nx;
    end
  end

  // outputs read as idle for as long as reset is held
  assign bus.gray_req  = req & ~reset;
  assign bus.gray_addr = reset ? 6'd0 : raddr;
  assign bus.win_valid = wvalid & ~reset;
  assign bus.win_data  = reset ? 72'd0 : win;
  assign bus.win_addr  = reset ? 6'd0 : {row, col};
  assign bus.lbp_write = lwrite & ~reset;
  assign bus.lbp_addr  = reset ? 6'd0 : laddr;
  assign bus.lbp_data  = reset ? 8'd0 : ldata;
  assign bus.finish    = fin & ~reset;

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Scoreboard bench for lbp_scan_ctrl: gray/result memory and datapath
// models, queued expectations popped by a monitor, plus reset abort.
module tb_lbp_scan_ctrl;

  typedef struct packed {
    logic [5:0]  a;
    logic [71:0] d;
  } win_e;

  typedef struct packed {
    logic [5:0] a;
    logic [7:0] d;
  } wr_e;

  logic clk = 1'b0;
  logic reset;

  lbp_scan_ctrl_if bus ();

  lbp_scan_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] gray_m [64];
  logic [7:0] res_m  [64];

  logic [5:0] rd_q [$];
  win_e       win_q [$];
  wr_e        wr_q [$];

  logic [5:0] tbl_a [9] = '{6'd0, 6'd8, 6'd16, 6'd1, 6'd9,
                            6'd17, 6'd2, 6'd10, 6'd18};
  logic [5:0] tbl_b [3] = '{6'd3, 6'd11, 6'd19};
  logic [5:0] tbl_c [9] = '{6'd8, 6'd16, 6'd24, 6'd9, 6'd17,
                            6'd25, 6'd10, 6'd18, 6'd26};
  logic [5:0] tbl_w [7] = '{6'd9, 6'd10, 6'd11, 6'd12,
                            6'd13, 6'd14, 6'd17};

  logic mon_en = 1'b0;

  task automatic chk(input string nm, input logic [71:0] act,
                     input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event", nm);
  endtask

  function automatic int center(input int i);
    return (1 + i / 6) * 8 + 1 + i % 6;
  endfunction

  task automatic push_expected();
    int r;
    int c;
    logic [71:0] w;
    for (int i = 0; i < 36; i++) begin
      r = 1 + i / 6;
      c = 1 + i % 6;
      if (c == 1) begin
        for (int dc = 0; dc < 3; dc++)
          for (int dr = 0; dr < 3; dr++)
            rd_q.push_back(6'((r - 1 + dr) * 8 + dc));
      end else begin
        for (int dr = 0; dr < 3; dr++)
          rd_q.push_back(6'((r - 1 + dr) * 8 + c + 1));
      end
      for (int k = 0; k < 9; k++)
        w[8*k +: 8] = gray_m[(r - 1 + k / 3) * 8 + c - 1 + k % 3];
      win_q.push_back('{a: 6'(r * 8 + c), d: w});
      wr_q.push_back('{a: 6'(r * 8 + c), d: gray_m[r * 8 + c]});
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gray_req"},  72'(bus.gray_req),  72'd0);
    chk({tag, "_gray_addr"}, 72'(bus.gray_addr), 72'd0);
    chk({tag, "_win_valid"}, 72'(bus.win_valid), 72'd0);
    chk({tag, "_win_data"},  bus.win_data,       72'd0);
    chk({tag, "_win_addr"},  72'(bus.win_addr),  72'd0);
    chk({tag, "_lbp_write"}, 72'(bus.lbp_write), 72'd0);
    chk({tag, "_lbp_addr"},  72'(bus.lbp_addr),  72'd0);
    chk({tag, "_lbp_data"},  72'(bus.lbp_data),  72'd0);
    chk({tag, "_finish"},    72'(bus.finish),    72'd0);
  endtask

  // gray memory (one-cycle read) and LBP datapath model
  int         win_idx = 0;
  int         pend = 0;
  int         vcnt = 0;
  int         hold;
  logic       prev_req = 1'b0;
  logic [5:0] prev_addr = 6'd0;

  always @(negedge clk) begin
    #1;
    if (prev_req) bus.gray_data = gray_m[prev_addr];
    prev_req  = bus.gray_req;
    prev_addr = bus.gray_addr;
    if (reset) begin
      win_idx       = 0;
      pend          = 0;
      vcnt          = 0;
      bus.win_ready = 1'b0;
      bus.res_valid = 1'b0;
    end else begin
      bus.res_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.res_valid = 1'b1;
          bus.res_data  = gray_m[center(win_idx - 1)];
        end
      end
      if (bus.win_valid) vcnt++;
      else vcnt = 0;
      hold = (win_idx == 2) ? 20 : 1;
      // stray result while the window is still on offer
      if (win_idx == 2 && vcnt == 5) begin
        bus.res_valid = 1'b1;
        bus.res_data  = 8'hAA;
      end
      bus.win_ready = bus.win_valid && (vcnt > hold);
      if (bus.win_ready) begin
        win_idx++;
        pend = 3;
      end
    end
  end

  // monitor
  int         cyc = 0;
  int         first_cyc = 0;
  int         rd_cnt = 0;
  int         wr_cnt = 0;
  int         wn = 0;
  int         viol = 0;
  logic       wv_prev = 1'b0;
  logic       hold_chk = 1'b0;
  win_e       exp_w;
  wr_e        exp_wr;

  always @(negedge clk) begin
    #2;
    cyc++;
    if (int'(bus.gray_req) + int'(bus.win_valid) + int'(bus.lbp_write) > 1)
      viol++;
    if (mon_en) begin
      if (bus.gray_req) begin
        if (rd_cnt == 0) first_cyc = cyc;
        if (rd_q.size() == 0) fail("rd_extra");
        else chk("rd_addr", 72'(bus.gray_addr), 72'(rd_q.pop_front()));
        if (rd_cnt < 9)
          chk("rd_first_hand", 72'(bus.gray_addr), 72'(tbl_a[rd_cnt]));
        else if (rd_cnt < 12)
          chk("rd_second_hand", 72'(bus.gray_addr), 72'(tbl_b[rd_cnt - 9]));
        else if (rd_cnt >= 24 && rd_cnt < 33)
          chk("rd_row2_hand", 72'(bus.gray_addr), 72'(tbl_c[rd_cnt - 24]));
        rd_cnt++;
      end
      if (bus.win_valid && !wv_prev) begin
        if (wn == 0) chk("win_latency", 72'(cyc - first_cyc), 72'd10);
        if (wn < 7) chk("win_center_hand", 72'(bus.win_addr), 72'(tbl_w[wn]));
        if (win_q.size() == 0) begin
          fail("win_extra");
          exp_w = '0;
        end else begin
          exp_w = win_q.pop_front();
        end
        wn++;
      end
      if (bus.win_valid) begin
        chk("win_addr", 72'(bus.win_addr), 72'(exp_w.a));
        chk("win_data", bus.win_data, exp_w.d);
      end
      if (hold_chk) begin
        chk("wr_second_cycle_strobe", 72'(bus.lbp_write), 72'd0);
        chk("wr_addr_held", 72'(bus.lbp_addr), 72'(exp_wr.a));
        chk("wr_data_held", 72'(bus.lbp_data), 72'(exp_wr.d));
        hold_chk = 1'b0;
      end else if (bus.lbp_write) begin
        res_m[bus.lbp_addr] = bus.lbp_data;
        if (wr_q.size() == 0) begin
          fail("wr_extra");
          exp_wr = '0;
        end else begin
          exp_wr = wr_q.pop_front();
          chk("wr_addr", 72'(bus.lbp_addr), 72'(exp_wr.a));
          chk("wr_data", 72'(bus.lbp_data), 72'(exp_wr.d));
        end
        hold_chk = 1'b1;
        wr_cnt++;
      end
    end
    wv_prev = bus.win_valid;
  end

  initial begin
    int n;
    logic [7:0] e;
    reset         = 1'b1;
    bus.win_ready = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_data  = 8'd0;
    bus.gray_data = 8'd0;
    for (int i = 0; i < 64; i++) begin
      gray_m[i] = 8'(i * 7 + 1);
      res_m[i]  = 8'd0;
    end
    push_expected();

    repeat (3) @(negedge clk);
    #3;
    chk_idle("rst");

    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    for (int t = 0; t < 4000 && !bus.finish; t++) @(negedge clk);
    #3;
    chk("finish", 72'(bus.finish), 72'd1);
    repeat (3) @(negedge clk);
    #3;
    chk("done_strobes",
        72'({bus.gray_req, bus.win_valid, bus.lbp_write}), 72'd0);
    chk("done_finish_held", 72'(bus.finish), 72'd1);
    mon_en = 1'b0;

    chk("read_cycles", 72'(rd_cnt), 72'd144);
    chk("write_strobes", 72'(wr_cnt), 72'd36);
    chk("windows", 72'(wn), 72'd36);
    chk("rd_q_empty", 72'(rd_q.size()), 72'd0);
    chk("win_q_empty", 72'(win_q.size()), 72'd0);
    chk("wr_q_empty", 72'(wr_q.size()), 72'd0);
    chk("strobe_overlap", 72'(viol), 72'd0);
    chk("res_9_hand", 72'(res_m[9]), 72'd64);
    chk("res_54_hand", 72'(res_m[54]), 72'd123);
    for (int i = 0; i < 64; i++) begin
      if (i / 8 >= 1 && i / 8 <= 6 && i % 8 >= 1 && i % 8 <= 6)
        e = gray_m[i];
      else
        e = 8'd0;
      chk("res_mem", 72'(res_m[i]), 72'(e));
    end

    // abort mid-FETCH of the third window
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int t = 0; t < 300 && n < 13; t++) begin
      @(negedge clk);
      #3;
      if (bus.gray_req) n++;
    end
    chk("abort_reached_third_fetch", 72'(n), 72'd13);
    @(negedge clk);
    reset = 1'b1;
    #3;
    chk_idle("abort");
    @(negedge clk);
    reset = 1'b0;
    #3;
    chk("restart_req", 72'(bus.gray_req), 72'd1);
    chk("restart_addr0", 72'(bus.gray_addr), 72'd0);
    chk("restart_no_write", 72'(bus.lbp_write), 72'd0);
    @(negedge clk);
    #3;
    chk("restart_addr8", 72'(bus.gray_addr), 72'd8);
    @(negedge clk);
    #3;
    chk("restart_addr16", 72'(bus.gray_addr), 72'd16);
    chk("strobe_overlap_final", 72'(viol), 72'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
